// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding, requester grant id,
// and the wait-state counter width.
package sram_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_LDR = 1'b1
   } grant_e;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin pick.
//   req[0]     : CPU request
//   req[1]     : loader request
//   last_grant : requester served most recently
//   gnt        : chosen requester (meaningful only when vld)
//   vld        : at least one request pending
module rr_arb2
   import sram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  grant_e     last_grant,
   output grant_e     gnt,
   output logic       vld
);

   always_comb begin
      gnt = GNT_CPU;
      vld = |req;
      if (req == 2'b11) begin
         // Tie: serve whoever did not go last.
         gnt = (last_grant == GNT_CPU) ? GNT_LDR : GNT_CPU;
      end else if (req[1]) begin
         gnt = GNT_LDR;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between the CPU datapath and the
// program loader/debug port, generating the active-low strobes and the
// read/write wait states so each requester only sees a req/ack handshake.
//
// Ports:
//   Clk, Reset                      clock, async active-high reset
//   cpu_req/we/addr/wdata           CPU request (addr/we/wdata sampled at grant)
//   cpu_rdata, cpu_ack              CPU read data and one-cycle completion pulse
//   ldr_*                           same set for the loader
//   sram_addr, sram_dout, sram_drive  SRAM address, write data, tristate enable
//   sram_din                        SRAM read data
//   Mem_CE/UB/LB/OE/WE              active-low SRAM strobes
//   busy                            FSM is not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access; arbitrate and latch the winning request
// READ  | CE/OE low, counting down read wait states, capture at zero
// WRITE | CE/WE low, data driven, counting down write wait states
// DONE  | strobes released, ack the granted requester, hold data on write
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 16,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dout,
   output logic              sram_drive,
   input  logic [DATA_W-1:0] sram_din,
   output logic              Mem_CE,
   output logic              Mem_UB,
   output logic              Mem_LB,
   output logic              Mem_OE,
   output logic              Mem_WE,
   output logic              busy
);

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   grant_e              gnt_q, gnt_d;
   grant_e              last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                ldr_ack_q, ldr_ack_d;
   logic                ce_n_q, ce_n_d;
   logic                oe_n_q, oe_n_d;
   logic                we_n_q, we_n_d;
   logic                drive_q, drive_d;

   grant_e              arb_gnt;
   logic                arb_vld;

   rr_arb2 u_rr_arb2 (
      .req        ({ldr_req, cpu_req}),
      .last_grant (last_q),
      .gnt        (arb_gnt),
      .vld        (arb_vld)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      cpu_ack_d   = 1'b0;
      ldr_ack_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (arb_vld) begin
               gnt_d  = arb_gnt;
               last_d = arb_gnt;
               if (arb_gnt == GNT_CPU) begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
               end else begin
                  we_d    = ldr_we;
                  addr_d  = ldr_addr;
                  wdata_d = ldr_wdata;
               end
               if (we_d) begin
                  state_d = WRITE;
                  cnt_d   = WR_LOAD;
               end else begin
                  state_d = READ;
                  cnt_d   = RD_LOAD;
               end
            end
         end
         READ: begin
            if (cnt_q == '0) begin
               if (gnt_q == GNT_CPU) begin
                  cpu_rdata_d = sram_din;
                  cpu_ack_d   = 1'b1;
               end else begin
                  ldr_rdata_d = sram_din;
                  ldr_ack_d   = 1'b1;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WRITE: begin
            if (cnt_q == '0) begin
               cpu_ack_d = (gnt_q == GNT_CPU);
               ldr_ack_d = (gnt_q == GNT_LDR);
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Strobes are registered from the next state so they leave the block
      // glitch-free and line up with the state they describe.
      ce_n_d  = !((state_d == READ) || (state_d == WRITE));
      oe_n_d  = (state_d != READ);
      we_n_d  = (state_d != WRITE);
      // Keep driving one extra cycle after a write for data hold time.
      drive_d = (state_d == WRITE) || ((state_d == DONE) && we_d);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_q       <= GNT_CPU;
         last_q      <= GNT_LDR;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         ldr_ack_q   <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         drive_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         ldr_ack_q   <= ldr_ack_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         drive_q     <= drive_d;
      end
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign ldr_rdata  = ldr_rdata_q;
   assign cpu_ack    = cpu_ack_q;
   assign ldr_ack    = ldr_ack_q;
   assign sram_addr  = addr_q;
   assign sram_dout  = wdata_q;
   assign sram_drive = drive_q;
   assign Mem_CE     = ce_n_q;
   assign Mem_UB     = ce_n_q;
   assign Mem_LB     = ce_n_q;
   assign Mem_OE     = oe_n_q;
   assign Mem_WE     = we_n_q;
   assign busy       = (state_q != IDLE);

endmodule
